// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch stage.
// Widths, instruction size and fetch FSM states.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd4;

    typedef enum logic {
        S_BOOT,
        S_RUN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between PC logic and decode.
// Head entry is registered so decode sees stable outputs.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    import riscv_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(
        input logic [AW-1:0] p
    );
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count_n = count + CW'(do_push)
                   - CW'(do_pop);

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count_n;
        end
    end

    // entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // registered head: bypass din when it becomes the head
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            dout <= '0;
        end else if (count_n != '0) begin
            if (count == '0 ||
                (do_pop && count == CW'(1))) begin
                dout <= din;
            end else if (do_pop) begin
                dout <= mem[bump(rd_ptr)];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads imem, feeds decode.
// Boot delay, back-pressure and redirect with flush.
module instr_fetch_unit #(
    parameter int              XLEN        = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC    =
        XLEN'(riscv_pkg::RESET_PC_DEFAULT),
    parameter int              IMEM_BYTES  = 256,
    parameter int              FIFO_DEPTH  = 2,
    parameter int              BOOT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            booting
);
    import riscv_pkg::*;

    localparam int BW = $clog2(BOOT_CYCLES + 2);
    localparam int EW = 2 * XLEN;

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [BW-1:0]   boot_cnt;
    logic            boot_last;
    logic            fetch_en;
    logic [XLEN-1:0] pc;
    logic [XLEN:0]   pc_sum;
    logic [XLEN-1:0] pc_inc;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;
    logic [EW-1:0]   head;

    assign boot_last = (boot_cnt <= BW'(1));
    assign pop       = if_valid && if_ready;
    assign push      = fetch_en && !redirect_valid
                    && (!full || pop);

    assign pc_sum = {1'b0, pc}
                  + (XLEN + 1)'(INSTR_BYTES);
    assign pc_inc =
        (pc_sum >= (XLEN + 1)'(IMEM_BYTES))
        ? '0 : pc_sum[XLEN-1:0];

    assign imem_addr = pc;
    assign if_valid  = !empty;
    assign if_pc     = head[EW-1:XLEN];
    assign if_instr  = head[XLEN-1:0];

    // fetch state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_n;
        end
    end

    // leave boot once the idle cycles are spent
    always_comb begin
        state_n = state;
        case (state)
            S_BOOT:  if (boot_last) state_n = S_RUN;
            S_RUN:   state_n = S_RUN;
            default: state_n = S_BOOT;
        endcase
    end

    // state-derived controls
    always_comb begin
        booting  = 1'b0;
        fetch_en = 1'b0;
        case (state)
            S_BOOT:  booting  = 1'b1;
            S_RUN:   fetch_en = 1'b1;
            default: booting  = 1'b1;
        endcase
    end

    // boot idle counter, saturates at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            boot_cnt <= BW'(BOOT_CYCLES);
        end else if (state == S_BOOT &&
                     boot_cnt != '0) begin
            boot_cnt <= boot_cnt - BW'(1);
        end
    end

    // PC: redirect wins, else advance on push
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            unique case (1'b1)
                redirect_valid:
                    pc <= {redirect_pc[XLEN-1:2], 2'b00};
                push:
                    pc <= pc_inc;
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({pc, imem_rdata}),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit.
// Directed phases: boot, stall, toggle, redirect, wrap, reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        booting;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb [$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(
        input logic [31:0] a
    );
        if (a == 32'd4) begin
            return 32'h0420_E1B3;
        end
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instr_fetch_unit #(
        .XLEN        (32),
        .RESET_PC    (32'd4),
        .IMEM_BYTES  (256),
        .FIFO_DEPTH  (2),
        .BOOT_CYCLES (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .booting        (booting)
    );

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] p);
        sb.push_back({p, mem_word(p)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drained(input string name);
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset(input logic rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        step();
        step();
        reset    = 1'b0;
        if_ready = rdy;
    endtask

    // monitor: every accepted head must match the scoreboard
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready &&
            !redirect_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_delivery pc=%h",
                         if_pc);
            end else begin
                mon_e = sb.pop_front();
                check("deliv_pc", if_pc, mon_e[63:32]);
                check("deliv_instr", if_instr,
                      mon_e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_ready       = 1'b0;

        // boot and streaming
        expect_pc(32'd4);
        expect_pc(32'd8);
        expect_pc(32'd12);
        expect_pc(32'd16);
        do_reset(1'b1);
        check("rst_booting", 32'(booting), 32'd1);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_addr", imem_addr, 32'd4);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        step();
        check("boot_done", 32'(booting), 32'd0);
        check("boot_novalid", 32'(if_valid), 32'd0);
        step();
        check("first_valid", 32'(if_valid), 32'd1);
        check("first_pc", if_pc, 32'd4);
        check("first_instr", if_instr, 32'h0420_E1B3);
        check("first_addr", imem_addr, 32'd8);
        step();
        step();
        step();
        check("stream_pc", if_pc, 32'd16);
        step();
        if_ready = 1'b0;
        step();
        sb_drained("p1_drained");

        // back-pressure
        do_reset(1'b0);
        step();
        step();
        check("bp_valid", 32'(if_valid), 32'd1);
        check("bp_addr0", imem_addr, 32'd8);
        repeat (4) step();
        check("bp_hold_pc", if_pc, 32'd4);
        check("bp_hold_addr", imem_addr, 32'd12);
        check("bp_hold_instr", if_instr,
              32'h0420_E1B3);
        expect_pc(32'd4);
        expect_pc(32'd8);
        expect_pc(32'd12);
        if_ready = 1'b1;
        step();
        check("bp_nogap1", 32'(if_valid), 32'd1);
        check("bp_pc8", if_pc, 32'd8);
        step();
        check("bp_nogap2", 32'(if_valid), 32'd1);
        check("bp_pc12", if_pc, 32'd12);
        step();
        if_ready = 1'b0;
        sb_drained("p2_drained");
        check("bp_addr24", imem_addr, 32'd24);

        // full FIFO with pop and push together
        expect_pc(32'd16);
        step();
        step();
        check("tog_full_addr", imem_addr, 32'd24);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        check("tog_pc20", if_pc, 32'd20);
        check("tog_addr28", imem_addr, 32'd28);
        expect_pc(32'd20);
        step();
        step();
        check("tog_full_addr2", imem_addr, 32'd28);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        check("tog_pc24", if_pc, 32'd24);
        check("tog_addr32", imem_addr, 32'd32);
        sb_drained("p3_drained");

        // redirect with a full FIFO
        do_reset(1'b0);
        step();
        step();
        step();
        expect_pc(32'd4);
        expect_pc(32'd8);
        expect_pc(32'h28);
        expect_pc(32'h2C);
        if_ready = 1'b1;
        step();
        step();
        check("pre_redir_pc", if_pc, 32'd12);
        check("pre_redir_addr", imem_addr, 32'd20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2B;
        step();
        redirect_valid = 1'b0;
        check("redir_flush", 32'(if_valid), 32'd0);
        check("redir_addr", imem_addr, 32'h28);
        step();
        check("redir_valid", 32'(if_valid), 32'd1);
        check("redir_pc", if_pc, 32'h28);
        step();
        check("redir_pc2", if_pc, 32'h2C);
        step();
        sb_drained("p4_drained");

        // wrap at the top of instruction memory
        expect_pc(32'd252);
        expect_pc(32'd0);
        expect_pc(32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd252;
        step();
        redirect_valid = 1'b0;
        check("wrap_flush", 32'(if_valid), 32'd0);
        check("wrap_addr", imem_addr, 32'd252);
        step();
        check("wrap_pc252", if_pc, 32'd252);
        check("wrap_addr0", imem_addr, 32'd0);
        step();
        check("wrap_pc0", if_pc, 32'd0);
        step();
        check("wrap_pc4", if_pc, 32'd4);
        step();
        if_ready = 1'b0;
        sb_drained("p5_drained");

        // reset beats a same-cycle redirect
        step();
        check("pre_rst_valid", 32'(if_valid), 32'd1);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        check("mrst_valid", 32'(if_valid), 32'd0);
        check("mrst_addr", imem_addr, 32'd4);
        check("mrst_booting", 32'(booting), 32'd1);
        check("mrst_if_pc", if_pc, 32'd0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        expect_pc(32'd4);
        step();
        step();
        check("mrst_first_pc", if_pc, 32'd4);
        step();
        if_ready = 1'b0;
        sb_drained("p6_drained");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
